// File: rtl/fp_mult_round_pack.sv
// Round/pack stage of the FP multiplier: rounds to nearest-even, resolves specials,
// overflow and underflow, and emits a packed IEEE-754 word through a 2-deep pipeline.
module fp_mult_round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W:0]            in_exp,
    input  logic [FRAC_W-1:0]         in_frac,
    input  logic                      in_g,
    input  logic                      in_r,
    input  logic                      in_s,
    input  logic                      in_nan,
    input  logic                      in_inf,
    input  logic                      in_zero,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_ovf,
    output logic                      out_unf,
    output logic                      out_inexact
);

    localparam logic [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

    logic                s1Valid;
    logic                s1Sign;
    logic [EXP_W:0]      s1Exp;
    logic [FRAC_W+1:0]   s1Sum;
    logic                s1Inexact;
    logic                s1Nan;
    logic                s1Inf;
    logic                s1Zero;

    logic                adv1;
    logic                adv2;
    logic                roundUp;
    logic [FRAC_W+1:0]   sumNext;

    logic [EXP_W+1:0]    expAdj;
    logic [EXP_W+FRAC_W:0] resNext;
    logic                ovfNext;
    logic                unfNext;
    logic                inexNext;

    assign adv2     = out_valid ? out_ready : 1'b1;
    assign adv1     = !s1Valid || adv2;
    assign in_ready = adv1;

    assign roundUp = in_g && (in_r || in_s || in_frac[0]);
    assign sumNext = {2'b01, in_frac} + (FRAC_W+2)'(roundUp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid   <= 1'b0;
            s1Sign    <= 1'b0;
            s1Exp     <= '0;
            s1Sum     <= '0;
            s1Inexact <= 1'b0;
            s1Nan     <= 1'b0;
            s1Inf     <= 1'b0;
            s1Zero    <= 1'b0;
        end else if (adv1) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Sign    <= in_sign;
                s1Exp     <= in_exp;
                s1Sum     <= sumNext;
                s1Inexact <= in_g || in_r || in_s;
                s1Nan     <= in_nan;
                s1Inf     <= in_inf;
                s1Zero    <= in_zero;
            end
        end
    end

    // One extra exponent bit so a carry out of a saturated 2^(EXP_W+1)-1 cannot wrap.
    assign expAdj = {1'b0, s1Exp} + (EXP_W+2)'(s1Sum[FRAC_W+1]);

    always_comb begin
        resNext  = {s1Sign, expAdj[EXP_W-1:0], s1Sum[FRAC_W-1:0]};
        ovfNext  = 1'b0;
        unfNext  = 1'b0;
        inexNext = s1Inexact;
        if (s1Sum[FRAC_W+1]) begin
            resNext[FRAC_W-1:0] = '0;
        end
        if (expAdj >= EXP_MAX) begin
            resNext  = {s1Sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovfNext  = 1'b1;
            inexNext = 1'b1;
        end else if (expAdj == '0) begin
            resNext  = {s1Sign, {(EXP_W+FRAC_W){1'b0}}};
            unfNext  = 1'b1;
            inexNext = 1'b1;
        end
        if (s1Nan || (s1Inf && s1Zero)) begin
            resNext  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            ovfNext  = 1'b0;
            unfNext  = 1'b0;
            inexNext = 1'b0;
        end else if (s1Inf) begin
            resNext  = {s1Sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovfNext  = 1'b0;
            unfNext  = 1'b0;
            inexNext = 1'b0;
        end else if (s1Zero) begin
            resNext  = {s1Sign, {(EXP_W+FRAC_W){1'b0}}};
            ovfNext  = 1'b0;
            unfNext  = 1'b0;
            inexNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                out_result  <= resNext;
                out_ovf     <= ovfNext;
                out_unf     <= unfNext;
                out_inexact <= inexNext;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Bench for fp_mult_round_pack: directed vectors, an arithmetic reference model with a
// scoreboard queue, backpressure and mid-flight reset scenarios.
module tb_fp_mult_round_pack;

    typedef struct {
        logic        sign;
        logic [8:0]  exp;
        logic [22:0] frac;
        logic        g, r, s, nan, inf, zero;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign, in_g, in_r, in_s, in_nan, in_inf, in_zero;
    logic [8:0]  in_exp;
    logic [22:0] in_frac;
    logic        out_valid, out_ready, out_ovf, out_unf, out_inexact;
    logic [31:0] out_result;

    int total = 0;
    int bad = 0;
    int accCount = 0;
    int outCount = 0;
    logic [34:0] expQ[$];
    logic        prevHold = 1'b0;
    logic [34:0] prevOut;

    fp_mult_round_pack #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
        .in_g(in_g), .in_r(in_r), .in_s(in_s),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, unf, inexact, result} from plain integer arithmetic.
    function automatic logic [34:0] model(beat_t b);
        longint mant;
        int     e;
        logic   inx;
        logic [7:0]  e8;
        logic [22:0] f23;
        inx = b.g | b.r | b.s;
        if (b.nan || (b.inf && b.zero)) return {3'b000, 32'h7FC00000};
        if (b.inf)  return {3'b000, b.sign, 31'h7F800000};
        if (b.zero) return {3'b000, b.sign, 31'h0};
        mant = 64'd8388608 + longint'(b.frac);
        if (b.g && (b.r || b.s || (mant % 2 == 1))) mant = mant + 1;
        e = int'(b.exp);
        if (mant >= 64'd16777216) begin
            mant = mant / 2;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, b.sign, 8'hFF, 23'h0};
        if (e == 0)   return {3'b011, b.sign, 31'h0};
        e8  = e[7:0];
        f23 = mant[22:0];
        return {2'b00, inx, b.sign, e8, f23};
    endfunction

    function automatic beat_t mk(logic sg, logic [8:0] ex, logic [22:0] fr,
                                 logic [2:0] grs, logic [2:0] spc);
        beat_t b;
        b.sign = sg; b.exp = ex; b.frac = fr;
        b.g = grs[2]; b.r = grs[1]; b.s = grs[0];
        b.nan = spc[2]; b.inf = spc[1]; b.zero = spc[0];
        return b;
    endfunction

    task automatic check(string name, logic [34:0] act, logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(beat_t b);
        in_sign = b.sign; in_exp = b.exp; in_frac = b.frac;
        in_g = b.g; in_r = b.r; in_s = b.s;
        in_nan = b.nan; in_inf = b.inf; in_zero = b.zero;
    endtask

    // Present one beat until accepted; returns at #1 after the accepting edge.
    task automatic sendBeat(beat_t b);
        logic acc;
        int   n;
        drive(b);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (expQ.size() != 0 || out_valid) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
    endtask

    // Scoreboard: all transfers observed mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                beat_t b;
                b = mk(in_sign, in_exp, in_frac, {in_g, in_r, in_s}, {in_nan, in_inf, in_zero});
                expQ.push_back(model(b));
                accCount++;
            end
            if (prevHold)
                check("hold_stable", {out_ovf, out_unf, out_inexact, out_result}, prevOut);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %h expected none", out_result);
                end else begin
                    check("result", {out_ovf, out_unf, out_inexact, out_result}, expQ.pop_front());
                end
                outCount++;
            end
            prevHold = out_valid && !out_ready;
            prevOut  = {out_ovf, out_unf, out_inexact, out_result};
        end else begin
            prevHold = 1'b0;
        end
    end

    beat_t vec[$];
    beat_t bp[4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(1'b0, 9'd0, 23'd0, 3'b000, 3'b000));

        // Pin the model with hand-computed values.
        check("m_one",     model(mk(0, 9'd127, 23'h000000, 3'b100 & 3'b000, 3'b000)), {3'b000, 32'h3F800000});
        check("m_tie_odd", model(mk(0, 9'd127, 23'h000001, 3'b100, 3'b000)), {3'b001, 32'h3F800002});
        check("m_tie_even",model(mk(0, 9'd127, 23'h000000, 3'b100, 3'b000)), {3'b001, 32'h3F800000});
        check("m_carry",   model(mk(0, 9'd127, 23'h7FFFFF, 3'b101, 3'b000)), {3'b001, 32'h40000000});
        check("m_ovf",     model(mk(0, 9'd254, 23'h7FFFFF, 3'b101, 3'b000)), {3'b101, 32'h7F800000});
        check("m_unf",     model(mk(1, 9'd0,   23'h123456, 3'b000, 3'b000)), {3'b011, 32'h80000000});
        check("m_nan",     model(mk(1, 9'd5,   23'h1,      3'b111, 3'b100)), {3'b000, 32'h7FC00000});
        check("m_inf",     model(mk(1, 9'd5,   23'h1,      3'b000, 3'b010)), {3'b000, 32'hFF800000});

        #12;
        check("reset_out", {out_valid, in_ready, out_ovf, out_unf, out_inexact, out_result},
              {1'b0, 1'b1, 3'b000, 32'h0});
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1 with explicit latency check.
        sendBeat(mk(0, 9'd127, 23'h0, 3'b000, 3'b000));
        check("lat1_early", {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        check("lat1_out", {out_valid, out_inexact, out_result}, {1'b1, 1'b0, 32'h3F800000});
        drain();

        // Directed stream at full throughput.
        vec.push_back(mk(0, 9'd127, 23'h000001, 3'b100, 3'b000));
        vec.push_back(mk(0, 9'd127, 23'h000000, 3'b100, 3'b000));
        vec.push_back(mk(0, 9'd127, 23'h7FFFFF, 3'b101, 3'b000));
        vec.push_back(mk(0, 9'd254, 23'h7FFFFF, 3'b101, 3'b000));
        vec.push_back(mk(1, 9'd0,   23'h000000, 3'b000, 3'b000));
        vec.push_back(mk(0, 9'd3,   23'h000000, 3'b000, 3'b100));
        vec.push_back(mk(1, 9'd3,   23'h000000, 3'b000, 3'b010));
        vec.push_back(mk(1, 9'd3,   23'h000000, 3'b000, 3'b011));
        vec.push_back(mk(1, 9'd3,   23'h000000, 3'b000, 3'b001));
        vec.push_back(mk(0, 9'd255, 23'h000010, 3'b000, 3'b000));
        vec.push_back(mk(0, 9'd511, 23'h7FFFFF, 3'b110, 3'b000));
        vec.push_back(mk(1, 9'd1,   23'h2AAAAA, 3'b010, 3'b000));
        vec.push_back(mk(0, 9'd200, 23'h000002, 3'b110, 3'b000));
        vec.push_back(mk(1, 9'd0,   23'h7FFFFF, 3'b111, 3'b000));
        foreach (vec[i]) sendBeat(vec[i]);
        drain();

        // Backpressure: 4 beats against a stalled output.
        bp[0] = mk(0, 9'd130, 23'h000011, 3'b000, 3'b000);
        bp[1] = mk(1, 9'd131, 23'h000022, 3'b100, 3'b000);
        bp[2] = mk(0, 9'd132, 23'h000033, 3'b110, 3'b000);
        bp[3] = mk(1, 9'd133, 23'h7FFFFF, 3'b100, 3'b000);
        begin
            int acc;
            int n;
            acc = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 6; c++) begin
                drive(bp[acc]);
                in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) acc++;
                @(posedge clk); #1;
            end
            check("bp_accepted", 35'(acc), 35'd2);
            check("bp_in_ready", {34'd0, in_ready}, 35'd0);
            out_ready = 1'b1;
            n = 0;
            while (acc < 4 && n < 50) begin
                drive(bp[acc]);
                in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) acc++;
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b0;
            check("bp_all_sent", 35'(acc), 35'd4);
        end
        drain();
        check("count_match", 35'(outCount), 35'(accCount));

        // Reset with two beats in flight.
        sendBeat(mk(0, 9'd140, 23'h1, 3'b000, 3'b000));
        sendBeat(mk(0, 9'd141, 23'h2, 3'b000, 3'b000));
        check("rst_pre_valid", {34'd0, out_valid}, 35'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drop", {33'd0, out_valid, in_ready}, 35'b01);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_empty", {34'd0, out_valid}, 35'd0);
        sendBeat(mk(0, 9'd127, 23'h0, 3'b000, 3'b000));
        check("lat2_early", {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        check("lat2_out", {out_valid, out_inexact, out_result}, {1'b1, 1'b0, 32'h3F800000});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
